// File: rtl/wave_reg_ctrl_if.sv
// wave_reg_ctrl_if: CPU byte bus plus wave-channel configuration outputs
interface wave_reg_ctrl_if #(parameter int LEN_W = 6);
   logic             apu_on;
   logic             wr_en;
   logic             rd_en;
   logic [7:0]       addr;
   logic [7:0]       wdata;
   logic [7:0]       rdata;
   logic             rdata_valid;
   logic             dac_en;
   logic [1:0]       vol;
   logic [LEN_W-1:0] length;
   logic             length_en;
   logic [10:0]      freq;
   logic             trigger;
   logic [127:0]     samples;
   modport master (
      output apu_on, wr_en, rd_en, addr, wdata,
      input  rdata, rdata_valid, dac_en, vol, length, length_en, freq, trigger, samples
   );
   modport slave (
      input  apu_on, wr_en, rd_en, addr, wdata,
      output rdata, rdata_valid, dac_en, vol, length, length_en, freq, trigger, samples
   );
endinterface

// File: rtl/wave_reg_ctrl.sv
// wave_reg_ctrl: NR30-NR34 register file and double-buffered wave RAM for the wave channel
module wave_reg_ctrl #(parameter int LEN_W = 6) (
   input logic            clk,
   input logic            reset,
   wave_reg_ctrl_if.slave bus
);
   typedef enum logic {IDLE, COMMIT} state_t;
   state_t           r_state, w_state_nxt;
   logic             r_dac_en, r_length_en, r_trig_pend, r_trigger, r_rdata_valid;
   logic [1:0]       r_vol;
   logic [LEN_W-1:0] r_length;
   logic [10:0]      r_freq;
   logic [127:0]     r_shadow, r_samples;
   logic [7:0]       r_rdata, w_rd, w_shadow_byte;
   logic [6:0]       w_idx;
   logic             w_wr_nr, w_wr_ram, w_dac_nxt, w_commit;
   // shadow is kept in sample order, so each RAM byte is stored nibble-swapped
   assign w_idx         = {bus.addr[3:0], 3'b000};
   assign w_wr_nr       = bus.wr_en && bus.apu_on;
   assign w_wr_ram      = bus.wr_en && bus.addr[7:4] == 4'h3;
   assign w_shadow_byte = {r_shadow[w_idx +: 4], r_shadow[w_idx + 7'd4 +: 4]};
   always_comb begin
      w_dac_nxt   = bus.apu_on && (w_wr_nr && bus.addr == 8'h1A ? bus.wdata[7] : r_dac_en);
      w_commit    = r_state == IDLE && r_trig_pend && w_dac_nxt;
      w_state_nxt = r_state == IDLE && r_trig_pend ? COMMIT : IDLE;
      w_rd        = bus.addr[7:4] == 4'h3 ? w_shadow_byte :
                    bus.addr == 8'h1A ? {r_dac_en, 7'h7F} :
                    bus.addr == 8'h1C ? {1'b1, r_vol, 5'h1F} :
                    bus.addr == 8'h1E ? {1'b1, r_length_en, 6'h3F} : 8'hFF;
   end
   // the copy is launched on the edge into COMMIT so live data and the pulse appear together
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_dac_en      <= 1'b0;
         r_vol         <= '0;
         r_length      <= '0;
         r_length_en   <= 1'b0;
         r_freq        <= '0;
         r_trig_pend   <= 1'b0;
         r_trigger     <= 1'b0;
         r_samples     <= '0;
         r_shadow      <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_trigger     <= w_commit;
         r_dac_en      <= w_dac_nxt;
         r_rdata_valid <= bus.rd_en;
         if (w_commit) r_samples <= r_shadow;
         if (bus.rd_en) r_rdata <= w_rd;
         if (w_wr_ram) r_shadow[w_idx +: 8] <= {bus.wdata[3:0], bus.wdata[7:4]};
         if (!bus.apu_on) begin
            r_vol       <= '0;
            r_length    <= '0;
            r_length_en <= 1'b0;
            r_freq      <= '0;
            r_trig_pend <= 1'b0;
         end else begin
            if (r_state == IDLE && r_trig_pend) r_trig_pend <= 1'b0;
            if (w_wr_nr && bus.addr == 8'h1B) r_length <= bus.wdata[LEN_W-1:0];
            if (w_wr_nr && bus.addr == 8'h1C) r_vol <= bus.wdata[6:5];
            if (w_wr_nr && bus.addr == 8'h1D) r_freq[7:0] <= bus.wdata;
            if (w_wr_nr && bus.addr == 8'h1E) begin
               r_freq[10:8] <= bus.wdata[2:0];
               r_length_en  <= bus.wdata[6];
               if (bus.wdata[7]) r_trig_pend <= 1'b1;
            end
         end
      end
   end
   assign bus.rdata       = r_rdata;
   assign bus.rdata_valid = r_rdata_valid;
   assign bus.dac_en      = r_dac_en;
   assign bus.vol         = r_vol;
   assign bus.length      = r_length;
   assign bus.length_en   = r_length_en;
   assign bus.freq        = r_freq;
   assign bus.trigger     = r_trigger;
   assign bus.samples     = r_samples;
endmodule

// File: tb/tb_wave_reg_ctrl.sv
// tb_wave_reg_ctrl: scoreboard bench for the wave-channel register controller
module tb_wave_reg_ctrl;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   int           checks = 0, errors = 0, n_trig = 0, base = 0;
   logic [7:0]   mdl [16];
   logic [7:0]   exp_q [$];
   logic [7:0]   rd_exp;
   logic [127:0] exp_vec, snap;

   wave_reg_ctrl_if #(.LEN_W(6)) bus ();
   wave_reg_ctrl #(.LEN_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // read scoreboard: every valid read pops the value pushed when it was issued
   always @(negedge clk) begin
      if (bus.trigger) n_trig++;
      if (bus.rdata_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rdata=%h with empty scoreboard", bus.rdata);
         end else begin
            rd_exp = exp_q.pop_front();
            if (bus.rdata !== rd_exp) begin
               errors++;
               $display("FAIL rd_data: got %h expected %h", bus.rdata, rd_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.wr_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      if (a[7:4] == 4'h3) mdl[a[3:0]] = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      exp_q.push_back(e);
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic rdwr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
      bus.rd_en = 1'b1;
      bus.wr_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      exp_q.push_back(e);
      if (a[7:4] == 4'h3) mdl[a[3:0]] = d;
      tick();
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   function automatic logic [127:0] mdl_vec();
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[8*k +: 8] = {mdl[k][3:0], mdl[k][7:4]};
      return v;
   endfunction

   task automatic chk_trig(input logic e, input string name);
      checks++;
      if (bus.trigger !== e) begin
         errors++;
         $display("FAIL %s: trigger=%b expected %b", name, bus.trigger, e);
      end
   endtask

   task automatic chk_samples(input logic [127:0] e, input string name);
      checks++;
      if (bus.samples !== e) begin
         errors++;
         $display("FAIL %s: samples=%h expected %h", name, bus.samples, e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
      checks++;
      if ({bus.dac_en, bus.vol, bus.length, bus.length_en, bus.freq} !== 21'd0) begin
         errors++;
         $display("FAIL reset_regs: dac=%b vol=%b len=%h len_en=%b freq=%h expected all 0",
                  bus.dac_en, bus.vol, bus.length, bus.length_en, bus.freq);
      end
      chk_trig(1'b0, "reset_trigger");
      chk_samples('0, "reset_samples");
      checks++;
      if (bus.rdata !== 8'h00 || bus.rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdata: rdata=%h valid=%b expected 00/0", bus.rdata, bus.rdata_valid);
      end
   endtask

   task automatic test_regs();
      base = n_trig;
      wr(8'h1A, 8'h80);
      wr(8'h1C, 8'h20);
      wr(8'h1D, 8'hD0);
      wr(8'h1E, 8'h07);
      wr(8'h1B, 8'hFF);
      checks++;
      if (bus.dac_en !== 1'b1) begin errors++; $display("FAIL regs_dac: got %b expected 1", bus.dac_en); end
      checks++;
      if (bus.vol !== 2'b01) begin errors++; $display("FAIL regs_vol: got %b expected 01", bus.vol); end
      checks++;
      if (bus.freq !== 11'd2000) begin errors++; $display("FAIL regs_freq: got %0d expected 2000", bus.freq); end
      checks++;
      if (bus.length_en !== 1'b0) begin errors++; $display("FAIL regs_len_en: got %b expected 0", bus.length_en); end
      checks++;
      if (bus.length !== 6'h3F) begin errors++; $display("FAIL regs_length: got %h expected 3f", bus.length); end
      wr(8'h25, 8'hFF);
      repeat (3) tick();
      checks++;
      if (n_trig !== base) begin errors++; $display("FAIL regs_no_trig: pulses=%0d expected 0", n_trig - base); end
      checks++;
      if (bus.vol !== 2'b01 || bus.freq !== 11'd2000) begin
         errors++;
         $display("FAIL regs_unmapped: vol=%b freq=%0d expected 01/2000", bus.vol, bus.freq);
      end
   endtask

   task automatic test_commit();
      logic [7:0] b;
      for (int k = 0; k < 16; k++) begin
         b = {4'(2*k), 4'(2*k + 1)};
         wr(8'h30 + 8'(k), b);
      end
      for (int n = 0; n < 32; n++) exp_vec[4*n +: 4] = 4'(n);
      chk_samples('0, "commit_shadow_only");
      base = n_trig;
      wr(8'h1E, 8'h87);
      chk_trig(1'b0, "commit_t1_trig");
      chk_samples('0, "commit_t1_samples");
      tick();
      chk_trig(1'b1, "commit_t2_trig");
      chk_samples(exp_vec, "commit_t2_samples");
      tick();
      chk_trig(1'b0, "commit_t3_trig");
      checks++;
      if (n_trig !== base + 1) begin errors++; $display("FAIL commit_pulses: got %0d expected 1", n_trig - base); end
   endtask

   task automatic test_dac_off();
      wr(8'h1A, 8'h00);
      wr(8'h30, 8'hFF);
      base = n_trig;
      wr(8'h1E, 8'h80);
      for (int i = 0; i < 10; i++) begin
         chk_trig(1'b0, "dac_off_trig");
         chk_samples(exp_vec, "dac_off_samples");
         tick();
      end
      checks++;
      if (n_trig !== base) begin errors++; $display("FAIL dac_off_pulses: got %0d expected 0", n_trig - base); end
   endtask

   task automatic test_reads();
      wr(8'h1C, 8'h60);
      checks++;
      if (bus.vol !== 2'b11) begin errors++; $display("FAIL reads_vol: got %b expected 11", bus.vol); end
      rd(8'h1C, 8'hFF);
      rd(8'h1A, 8'h7F);
      rd(8'h20, 8'hFF);
      rd(8'h1E, 8'hBF);
      rd(8'h1B, 8'hFF);
      rd(8'h1D, 8'hFF);
      rd(8'h30, 8'hFF);
      rd(8'h31, 8'h23);
      rdwr(8'h31, 8'h5A, 8'h23);
      rd(8'h31, 8'h5A);
      tick();
      tick();
      checks++;
      if (bus.rdata_valid !== 1'b0 || bus.rdata !== 8'h5A) begin
         errors++;
         $display("FAIL reads_hold: rdata=%h valid=%b expected 5a/0", bus.rdata, bus.rdata_valid);
      end
   endtask

   task automatic test_apu_off();
      bus.apu_on = 1'b0;
      tick();
      checks++;
      if ({bus.dac_en, bus.vol, bus.length, bus.length_en, bus.freq} !== 21'd0) begin
         errors++;
         $display("FAIL apu_off_clear: vol=%b len=%h freq=%h expected 0", bus.vol, bus.length, bus.freq);
      end
      wr(8'h1A, 8'h80);
      wr(8'h30, 8'hAB);
      wr(8'h1C, 8'h60);
      checks++;
      if (bus.dac_en !== 1'b0 || bus.vol !== 2'b00) begin
         errors++;
         $display("FAIL apu_off_ignore: dac=%b vol=%b expected 0/00", bus.dac_en, bus.vol);
      end
      chk_samples(exp_vec, "apu_off_samples_hold");
      rd(8'h30, 8'hAB);
      bus.apu_on = 1'b1;
      wr(8'h1A, 8'h80);
      checks++;
      if (bus.dac_en !== 1'b1) begin errors++; $display("FAIL apu_on_dac: got %b expected 1", bus.dac_en); end
      wr(8'h1E, 8'h80);
      tick();
      chk_trig(1'b1, "apu_on_trig");
      chk_samples(mdl_vec(), "apu_on_samples");
      checks++;
      if (bus.samples[3:0] !== 4'hA || bus.samples[7:4] !== 4'hB) begin
         errors++;
         $display("FAIL apu_on_s01: s0=%h s1=%h expected a/b", bus.samples[3:0], bus.samples[7:4]);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      base = n_trig;
      wr(8'h1E, 8'h80);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
      chk_trig(1'b0, "rst_mid_trig");
      chk_samples('0, "rst_mid_samples");
      checks++;
      if (bus.dac_en !== 1'b0 || bus.freq !== 11'd0 || bus.rdata !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_regs: dac=%b freq=%h rdata=%h expected 0", bus.dac_en, bus.freq, bus.rdata);
      end
      repeat (4) tick();
      checks++;
      if (n_trig !== base) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 0", n_trig - base); end
      wr(8'h1A, 8'h80);
      wr(8'h30, 8'h12);
      wr(8'h1E, 8'h80);
      tick();
      chk_trig(1'b1, "rst_after_trig");
      chk_samples(mdl_vec(), "rst_after_samples");
      checks++;
      if (bus.samples[7:0] !== 8'h21) begin
         errors++;
         $display("FAIL rst_after_byte0: got %h expected 21", bus.samples[7:0]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      base = n_trig;
      wr(8'h30, 8'h34);
      wr(8'h1E, 8'h80);
      tick();
      chk_trig(1'b1, "b2b_first");
      wr(8'h1E, 8'h80);
      chk_trig(1'b0, "b2b_gap");
      snap = mdl_vec();
      tick();
      chk_trig(1'b1, "b2b_second");
      chk_samples(snap, "b2b_samples");
      wr(8'h30, 8'h99);
      chk_trig(1'b0, "b2b_after");
      chk_samples(snap, "b2b_commit_prewrite");
      rd(8'h30, 8'h99);
      checks++;
      if (n_trig !== base + 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", n_trig - base); end
   endtask

   task automatic test_dac_race();
      base = n_trig;
      wr(8'h30, 8'h44);
      wr(8'h1E, 8'h80);
      wr(8'h1A, 8'h00);
      for (int i = 0; i < 4; i++) begin
         chk_trig(1'b0, "race_trig");
         tick();
      end
      chk_samples(snap, "race_samples");
      checks++;
      if (n_trig !== base) begin errors++; $display("FAIL race_pulses: got %0d expected 0", n_trig - base); end
   endtask

   initial begin
      bus.apu_on = 1'b1;
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;
      bus.addr   = 8'h00;
      bus.wdata  = 8'h00;
      test_reset();
      test_regs();
      test_commit();
      test_dac_off();
      test_reads();
      test_apu_off();
      test_reset_mid();
      test_back_to_back();
      test_dac_race();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_outstanding: %0d reads never returned, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
